jtpopeye_romarb: RTL and testbench
==================================

Name: jtpopeye_romarb

Overview:
- Arbiter sharing the single SDRAM read port among three ROM requesters: main CPU program ROM, background tile ROM and object ROM.
- The object requester supplies obj_addr and consumes a two-plane word pair, obj_data0/obj_data1. It has the highest priority because the object shift register reloads at a fixed pixel slot.
- Each requester has a one-entry tagged cache. Repeated reads of the same address are served without SDRAM traffic.

Parameters:
CPU_OFFSET, 22'h00_0000, SDRAM word base of CPU ROM (byte address = cpu_addr; word = base + cpu_addr[14:1])
BG_OFFSET, 22'h00_4000, SDRAM word base of background ROM
OBJ0_OFFSET, 22'h00_6000, SDRAM word base of object plane 0
OBJ1_OFFSET, 22'h00_8000, SDRAM word base of object plane 1
CPU_MAXWAIT, 3, consecutive lost grants after which a pending CPU request wins the next grant

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cpu_cs  in  1  CPU ROM read active
cpu_addr  in  15  CPU byte address
cpu_dout  out  8  CPU ROM byte
cpu_ok  out  1  cpu_dout valid for current cpu_addr
bg_cs  in  1  background fetch active
bg_addr  in  12  background word address
bg_data  out  16  background ROM word
bg_ok  out  1  bg_data valid for current bg_addr
obj_cs  in  1  object fetch active
obj_addr  in  13  object word address
obj_data0  out  16  plane 0 word
obj_data1  out  16  plane 1 word
obj_ok  out  1  both planes valid for current obj_addr
sdram_addr  out  22  SDRAM word address
sdram_rd  out  1  read request
sdram_ack  in  1  request accepted (1-cycle pulse)
sdram_rdy  in  1  read data valid (1-cycle pulse)
sdram_din  in  16  SDRAM read data

Behaviour:
- Reset:
  - Asynchronous, active-low: clk and rst_n, asynchronous active-low reset. One clock domain.
  - On reset, all outputs go to 0, all cache valid bits clear, FSM = IDLE, CPU wait counter = 0.
  - Reset mid-transaction abandons the transaction. Any sdram_rdy arriving after release is ignored while in IDLE.
- Cache:
  - Each requester keeps a tag (address captured at grant) and a valid bit.
  - pend_x = x_cs && !(valid_x && tag_x == x_addr).
  - x_ok = x_cs && valid_x && tag_x == x_addr. This is combinational on the registered tag, so ok drops in the same cycle the address changes.
- FSM states: IDLE, REQ, WAIT, REQ2, WAIT2.
  - IDLE: if any pend_x, select a winner, capture its tag, clear its valid, drive sdram_addr and sdram_rd=1, then go to REQ.
  - REQ: hold sdram_rd and sdram_addr until sdram_ack, then deassert sdram_rd and go to WAIT.
  - WAIT: on sdram_rdy, latch sdram_din into the winner's data register.
    - CPU or BG winner: set valid, go to IDLE.
    - OBJ winner: store plane 0, drive sdram_addr = OBJ1_OFFSET + tag, sdram_rd=1, go to REQ2.
  - REQ2/WAIT2: same handshake as REQ/WAIT for plane 1. On sdram_rdy, set obj valid and go to IDLE.
  - The grant stays locked across both object beats; no other requester is served between them.
  - sdram_ack and sdram_rdy arriving in the same cycle in REQ/REQ2 counts as completion of the beat.
- Priority at IDLE: obj > bg > cpu.
  - Exception: if the CPU is pending and cpu_wait == CPU_MAXWAIT, the CPU wins.
  - cpu_wait increments (saturating) on each grant to another requester while the CPU is pending. It clears on a CPU grant or when the CPU is not pending.
- Addresses:
  - CPU: CPU_OFFSET + cpu_addr[14:1]. cpu_dout = cpu_addr[0] ? data[15:8] : data[7:0]. The tag compares only cpu_addr[14:1], so byte changes within a word hit the cache.
  - BG: BG_OFFSET + bg_addr.
  - OBJ: OBJx_OFFSET + obj_addr.
  - All sums are 22-bit with wrap-around.
- Address change during a fetch: data still lands under the old tag. ok stays low because the tag mismatches, and a new fetch is issued from the next IDLE.
- cs deasserted during a fetch: the transaction still completes; the valid bit is set for the old tag.
- Latency, cache hit: x_ok in the same cycle as the address.
- Latency, miss with an idle port: sdram_rd rises 1 cycle after the request. x_ok rises 1 cycle after the final sdram_rdy.

Decomposition:
- jtpopeye_pkg holds the FSM state enum, the requester index constants (REQ_CPU=0, REQ_BG=1, REQ_OBJ=2) and the default offsets.
- One sub-module, jtpopeye_romarb_slot, is instantiated three times. It contains the tag, valid bit, data register(s), the pend/ok logic and a WORDS=1/2 parameter.
- Priority logic and FSM stay in the top module.

Test Plan:
- Reset: rst_n low mid-REQ2 → sdram_rd=0 and all ok=0 immediately; after release, a stray sdram_rdy leaves all data at 0.
- CPU miss: cpu_cs=1, cpu_addr=15'h0123 → sdram_addr=22'h000091, sdram_rd high until ack. sdram_din=16'hA55A → cpu_dout=8'hA5, cpu_ok=1. Changing to cpu_addr=15'h0122 gives 8'h5A with no new sdram_rd.
- Object pair: obj_addr=13'h0010 → sdram_addr 22'h006010 then 22'h008010, locked back-to-back. din 16'h1111 then 16'h2222 → obj_data0=16'h1111, obj_data1=16'h2222, obj_ok=1.
- Priority: cpu, bg and obj all miss together → grant order obj, bg, cpu.
- Starvation: CPU pending while obj/bg produce misses continuously → CPU granted after exactly 3 lost grants.
- Address change mid-WAIT: bg_addr changed 12'h001 → 12'h002 before sdram_rdy → bg_ok stays 0; a second fetch at 22'h004002 follows, then bg_ok=1.

Source files
------------

// File: rtl/jtpopeye_pkg.sv
// Shared definitions for the Popeye ROM arbiter: FSM states, requester
// indices, default SDRAM word bases and the word-address helper.
package jtpopeye_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_REQ2  = 3'd3,
      ST_WAIT2 = 3'd4
   } state_t;

   localparam logic [1:0] REQ_CPU = 2'd0;
   localparam logic [1:0] REQ_BG  = 2'd1;
   localparam logic [1:0] REQ_OBJ = 2'd2;

   localparam logic [21:0] DEF_CPU_OFFSET  = 22'h00_0000;
   localparam logic [21:0] DEF_BG_OFFSET   = 22'h00_4000;
   localparam logic [21:0] DEF_OBJ0_OFFSET = 22'h00_6000;
   localparam logic [21:0] DEF_OBJ1_OFFSET = 22'h00_8000;

   localparam int WAIT_W = 3;

   // 22-bit wrap-around sum of a region base and a zero-extended word offset
   function automatic logic [21:0] word_addr(input logic [21:0] base, input logic [13:0] off);
      return base + {8'd0, off};
   endfunction

endpackage

// File: rtl/jtpopeye_romarb_slot.sv
// One-entry tagged cache for a single ROM requester: tag, valid bit,
// one or two data words, and the pending/ok decode.
module jtpopeye_romarb_slot
   import jtpopeye_pkg::*;
#(
   parameter int AW    = 12,
   parameter int WORDS = 1
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_cs,
   input  logic [AW-1:0]        i_addr,
   input  logic                 i_grant,
   input  logic                 i_store,
   input  logic                 i_beat,
   input  logic                 i_done,
   input  logic [15:0]          i_din,
   output logic                 o_pend,
   output logic                 o_ok,
   output logic [16*WORDS-1:0]  o_data
);

   logic                r_valid;
   logic [AW-1:0]       r_tag;
   logic [16*WORDS-1:0] r_data;
   logic                w_hit;

   assign w_hit  = r_valid && (r_tag == i_addr);
   assign o_pend = i_cs && !w_hit;
   assign o_ok   = i_cs && w_hit;
   assign o_data = r_data;

   // Tag is captured at grant; data lands under that tag even if the requester moved on
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_tag   <= '0;
         r_data  <= '0;
      end else begin
         if (i_grant) begin
            r_tag   <= i_addr;
            r_valid <= 1'b0;
         end else if (i_done) begin
            r_valid <= 1'b1;
         end else begin
            r_valid <= r_valid;
         end
         if (i_store) begin
            if (i_beat) r_data[16*WORDS-1 -: 16] <= i_din;
            else        r_data[15:0]             <= i_din;
         end
      end
   end

endmodule

// File: rtl/jtpopeye_romarb.sv
// SDRAM read-port arbiter for CPU, background and object ROMs. Objects win
// by default and hold the port for both planes; a starved CPU is promoted.
module jtpopeye_romarb
   import jtpopeye_pkg::*;
#(
   parameter logic [21:0] CPU_OFFSET  = DEF_CPU_OFFSET,
   parameter logic [21:0] BG_OFFSET   = DEF_BG_OFFSET,
   parameter logic [21:0] OBJ0_OFFSET = DEF_OBJ0_OFFSET,
   parameter logic [21:0] OBJ1_OFFSET = DEF_OBJ1_OFFSET,
   parameter int          CPU_MAXWAIT = 3
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cpu_cs,
   input  logic [14:0] cpu_addr,
   output logic [7:0]  cpu_dout,
   output logic        cpu_ok,
   input  logic        bg_cs,
   input  logic [11:0] bg_addr,
   output logic [15:0] bg_data,
   output logic        bg_ok,
   input  logic        obj_cs,
   input  logic [12:0] obj_addr,
   output logic [15:0] obj_data0,
   output logic [15:0] obj_data1,
   output logic        obj_ok,
   output logic [21:0] sdram_addr,
   output logic        sdram_rd,
   input  logic        sdram_ack,
   input  logic        sdram_rdy,
   input  logic [15:0] sdram_din
);

   localparam logic [WAIT_W-1:0] LP_MAXWAIT = WAIT_W'(CPU_MAXWAIT);

   state_t              r_state;
   logic [1:0]          r_winner;
   logic [21:0]         r_sdram_addr;
   logic                r_sdram_rd;
   logic [WAIT_W-1:0]   r_cpu_wait;

   logic        w_cpu_pend, w_bg_pend, w_obj_pend, w_any_pend;
   logic        w_grant, w_beat, w_beat_done, w_last_beat;
   logic [1:0]  w_win;
   logic [21:0] w_win_addr;
   logic [15:0] w_cpu_word, w_bg_word;
   logic [31:0] w_obj_words;

   assign w_any_pend  = w_cpu_pend || w_bg_pend || w_obj_pend;
   assign w_grant     = (r_state == ST_IDLE) && w_any_pend;
   assign w_beat      = (r_state == ST_REQ2) || (r_state == ST_WAIT2);
   // ack and rdy together while still requesting also completes the beat
   assign w_beat_done = sdram_rdy && ((r_state == ST_WAIT) || (r_state == ST_WAIT2) ||
                        (sdram_ack && ((r_state == ST_REQ) || (r_state == ST_REQ2))));
   assign w_last_beat = w_beat || (r_winner != REQ_OBJ);

   // Winner selection and its first-beat SDRAM address
   always_comb begin
      w_win = REQ_CPU;
      if (w_cpu_pend && (r_cpu_wait == LP_MAXWAIT)) w_win = REQ_CPU;
      else if (w_obj_pend)                          w_win = REQ_OBJ;
      else if (w_bg_pend)                           w_win = REQ_BG;
      else                                          w_win = REQ_CPU;
      case (w_win)
         REQ_OBJ: w_win_addr = word_addr(OBJ0_OFFSET, {1'b0, obj_addr});
         REQ_BG:  w_win_addr = word_addr(BG_OFFSET, {2'b00, bg_addr});
         default: w_win_addr = word_addr(CPU_OFFSET, cpu_addr[14:1]);
      endcase
   end

   jtpopeye_romarb_slot #(.AW(14), .WORDS(1)) u_cpu (
      .clk(clk), .rst_n(rst_n), .i_cs(cpu_cs), .i_addr(cpu_addr[14:1]),
      .i_grant(w_grant && (w_win == REQ_CPU)),
      .i_store(w_beat_done && (r_winner == REQ_CPU)), .i_beat(w_beat),
      .i_done(w_beat_done && w_last_beat && (r_winner == REQ_CPU)), .i_din(sdram_din),
      .o_pend(w_cpu_pend), .o_ok(cpu_ok), .o_data(w_cpu_word)
   );

   jtpopeye_romarb_slot #(.AW(12), .WORDS(1)) u_bg (
      .clk(clk), .rst_n(rst_n), .i_cs(bg_cs), .i_addr(bg_addr),
      .i_grant(w_grant && (w_win == REQ_BG)),
      .i_store(w_beat_done && (r_winner == REQ_BG)), .i_beat(w_beat),
      .i_done(w_beat_done && w_last_beat && (r_winner == REQ_BG)), .i_din(sdram_din),
      .o_pend(w_bg_pend), .o_ok(bg_ok), .o_data(w_bg_word)
   );

   jtpopeye_romarb_slot #(.AW(13), .WORDS(2)) u_obj (
      .clk(clk), .rst_n(rst_n), .i_cs(obj_cs), .i_addr(obj_addr),
      .i_grant(w_grant && (w_win == REQ_OBJ)),
      .i_store(w_beat_done && (r_winner == REQ_OBJ)), .i_beat(w_beat),
      .i_done(w_beat_done && w_last_beat && (r_winner == REQ_OBJ)), .i_din(sdram_din),
      .o_pend(w_obj_pend), .o_ok(obj_ok), .o_data(w_obj_words)
   );

   // Transaction FSM; the object grant stays locked across both plane beats
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_winner     <= REQ_CPU;
         r_sdram_addr <= 22'd0;
         r_sdram_rd   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any_pend) begin
                  r_winner     <= w_win;
                  r_sdram_addr <= w_win_addr;
                  r_sdram_rd   <= 1'b1;
                  r_state      <= ST_REQ;
               end
            end
            ST_REQ, ST_REQ2: begin
               if (sdram_ack) begin
                  r_sdram_rd <= 1'b0;
                  r_state    <= w_beat ? ST_WAIT2 : ST_WAIT;
               end
            end
            ST_WAIT, ST_WAIT2: begin
               r_state <= r_state;
            end
            default: begin
               r_state    <= ST_IDLE;
               r_sdram_rd <= 1'b0;
            end
         endcase
         if (w_beat_done) begin
            if (w_last_beat) begin
               r_state    <= ST_IDLE;
               r_sdram_rd <= 1'b0;
            end else begin
               r_state      <= ST_REQ2;
               r_sdram_rd   <= 1'b1;
               r_sdram_addr <= r_sdram_addr - OBJ0_OFFSET + OBJ1_OFFSET;
            end
         end
      end
   end

   // CPU starvation counter: lost grants while the CPU keeps missing
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cpu_wait <= '0;
      end else if (!w_cpu_pend) begin
         r_cpu_wait <= '0;
      end else if (w_grant) begin
         if (w_win == REQ_CPU)              r_cpu_wait <= '0;
         else if (r_cpu_wait != LP_MAXWAIT) r_cpu_wait <= r_cpu_wait + WAIT_W'(1);
      end
   end

   assign sdram_addr = r_sdram_addr;
   assign sdram_rd   = r_sdram_rd;
   assign cpu_dout   = cpu_addr[0] ? w_cpu_word[15:8] : w_cpu_word[7:0];
   assign bg_data    = w_bg_word;
   assign obj_data0  = w_obj_words[15:0];
   assign obj_data1  = w_obj_words[31:16];

endmodule

// File: tb/tb_jtpopeye_romarb.sv
// Bench for jtpopeye_romarb: the bench plays the SDRAM and keeps a
// transaction-level model of the three caches, priority and starvation rules.
module tb_jtpopeye_romarb;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cpu_cs = 1'b0, bg_cs = 1'b0, obj_cs = 1'b0;
   logic [14:0] cpu_addr = '0;
   logic [11:0] bg_addr = '0;
   logic [12:0] obj_addr = '0;
   logic [7:0]  cpu_dout;
   logic [15:0] bg_data, obj_data0, obj_data1, sdram_din = '0;
   logic        cpu_ok, bg_ok, obj_ok, sdram_rd, sdram_ack = 1'b0, sdram_rdy = 1'b0;
   logic [21:0] sdram_addr;

   jtpopeye_romarb dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_cs(cpu_cs), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_ok(cpu_ok),
      .bg_cs(bg_cs), .bg_addr(bg_addr), .bg_data(bg_data), .bg_ok(bg_ok),
      .obj_cs(obj_cs), .obj_addr(obj_addr), .obj_data0(obj_data0), .obj_data1(obj_data1),
      .obj_ok(obj_ok), .sdram_addr(sdram_addr), .sdram_rd(sdram_rd),
      .sdram_ack(sdram_ack), .sdram_rdy(sdram_rdy), .sdram_din(sdram_din)
   );

   always #5 clk = ~clk;

   int n_vec = 0, n_err = 0;

   // model state: per requester 0=cpu 1=bg 2=obj
   bit          m_valid[3];
   int          m_tag[3];
   logic [15:0] m_d0[3];
   logic [15:0] m_d1;
   bit          m_busy, m_rd;
   int          m_win, m_beat, m_wait;
   logic [21:0] m_addr;
   int          rsp_delay;
   bit          rnd_mode, stray_en, stray_force;
   logic [15:0] force_q[$];
   logic [21:0] grant_q[$];
   bit          prev_rd;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int cur_tag(input int k);
      case (k)
         0: return int'(cpu_addr[14:1]);
         1: return int'(bg_addr);
         default: return int'(obj_addr);
      endcase
   endfunction

   function automatic bit cur_cs(input int k);
      case (k)
         0: return cpu_cs;
         1: return bg_cs;
         default: return obj_cs;
      endcase
   endfunction

   function automatic logic [21:0] base_of(input int k);
      case (k)
         0: return 22'h000000;
         1: return 22'h004000;
         default: return 22'h006000;
      endcase
   endfunction

   task automatic model_clear();
      for (int k = 0; k < 3; k++) begin
         m_valid[k] = 1'b0; m_tag[k] = 0; m_d0[k] = 16'h0000;
      end
      m_d1 = 16'h0000; m_busy = 1'b0; m_rd = 1'b0; m_win = 0; m_beat = 0;
      m_wait = 0; m_addr = 22'h0; rsp_delay = 0; prev_rd = 1'b0;
      force_q.delete();
   endtask

   task automatic compare();
      bit okx;
      chk("sdram_rd", 32'(sdram_rd), 32'(m_rd));
      if (m_rd) chk("sdram_addr", 32'(sdram_addr), 32'(m_addr));
      okx = cpu_cs && m_valid[0] && (m_tag[0] == cur_tag(0));
      chk("cpu_ok", 32'(cpu_ok), 32'(okx));
      if (okx) chk("cpu_dout", 32'(cpu_dout), 32'(cpu_addr[0] ? m_d0[0][15:8] : m_d0[0][7:0]));
      okx = bg_cs && m_valid[1] && (m_tag[1] == cur_tag(1));
      chk("bg_ok", 32'(bg_ok), 32'(okx));
      if (okx) chk("bg_data", 32'(bg_data), 32'(m_d0[1]));
      okx = obj_cs && m_valid[2] && (m_tag[2] == cur_tag(2));
      chk("obj_ok", 32'(obj_ok), 32'(okx));
      if (okx) begin
         chk("obj_data0", 32'(obj_data0), 32'(m_d0[2]));
         chk("obj_data1", 32'(obj_data1), 32'(m_d1));
      end
   endtask

   // one clock: SDRAM response + model step for the coming edge, then compare
   task automatic tick();
      bit ack_v, rdy_v, any;
      bit pend[3];
      logic [15:0] din_v;
      int w;
      ack_v = 1'b0; rdy_v = 1'b0; din_v = 16'($urandom);
      if (m_busy) begin
         if (m_rd) begin
            ack_v = rnd_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (ack_v) begin
               rsp_delay = rnd_mode ? $urandom_range(0, 3) : 1;
               rdy_v = (rsp_delay == 0);
            end
         end else begin
            rsp_delay--;
            rdy_v = (rsp_delay <= 0);
         end
         if (rdy_v && force_q.size() > 0) din_v = force_q.pop_front();
      end else if (stray_force || (stray_en && $urandom_range(0, 5) == 0)) begin
         rdy_v = 1'b1;
         ack_v = stray_en && ($urandom_range(0, 1) == 0);
         if (stray_force) din_v = 16'hFFFF;
      end
      sdram_ack = ack_v; sdram_rdy = rdy_v; sdram_din = din_v;

      any = 1'b0;
      for (int k = 0; k < 3; k++) begin
         pend[k] = cur_cs(k) && !(m_valid[k] && m_tag[k] == cur_tag(k));
         any = any || pend[k];
      end
      if (!m_busy) begin
         if (any) begin
            if (pend[0] && m_wait == 3) w = 0;
            else if (pend[2])           w = 2;
            else if (pend[1])           w = 1;
            else                        w = 0;
            if (pend[0]) m_wait = (w == 0) ? 0 : ((m_wait < 3) ? m_wait + 1 : 3);
            else         m_wait = 0;
            m_win = w; m_tag[w] = cur_tag(w); m_valid[w] = 1'b0;
            m_busy = 1'b1; m_beat = 0; m_rd = 1'b1;
            m_addr = base_of(w) + 22'(m_tag[w]);
         end else begin
            m_wait = 0;
         end
      end else begin
         if (!pend[0]) m_wait = 0;
         if (rdy_v) begin
            if (m_beat == 0) m_d0[m_win] = din_v; else m_d1 = din_v;
            if (m_win == 2 && m_beat == 0) begin
               m_beat = 1; m_rd = 1'b1; m_addr = 22'h008000 + 22'(m_tag[2]);
            end else begin
               m_valid[m_win] = 1'b1; m_busy = 1'b0; m_rd = 1'b0;
            end
         end else if (ack_v) begin
            m_rd = 1'b0;
         end
      end
      @(posedge clk);
      @(negedge clk);
      sdram_ack = 1'b0; sdram_rdy = 1'b0;
      compare();
      if (sdram_rd && !prev_rd) grant_q.push_back(sdram_addr);
      prev_rd = sdram_rd;
   endtask

   task automatic do_reset();
      cpu_cs = 1'b0; bg_cs = 1'b0; obj_cs = 1'b0;
      sdram_ack = 1'b0; sdram_rdy = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      model_clear();
      grant_q.delete();
      rst_n = 1'b1;
   endtask

   task automatic wait_ok(input int k, input int max);
      int n = 0;
      while (!((k == 0) ? cpu_ok : (k == 1) ? bg_ok : obj_ok) && n < max) begin
         tick(); n++;
      end
      chk("wait_ok", 32'((k == 0) ? cpu_ok : (k == 1) ? bg_ok : obj_ok), 32'd1);
   endtask

   initial begin
      int lost, n;
      bit seen;
      logic [21:0] exp_g[4];
      rnd_mode = 1'b0; stray_en = 1'b0; stray_force = 1'b0;
      model_clear();
      @(negedge clk);
      do_reset();

      // reset state
      chk("rst_sdram_rd", 32'(sdram_rd), 32'd0);
      chk("rst_sdram_addr", 32'(sdram_addr), 32'd0);
      chk("rst_oks", {29'd0, cpu_ok, bg_ok, obj_ok}, 32'd0);

      // CPU miss, then byte switch inside the same word
      cpu_cs = 1'b1; cpu_addr = 15'h0123; force_q.push_back(16'hA55A);
      tick();
      chk("cpu_rd", 32'(sdram_rd), 32'd1);
      chk("cpu_addr", 32'(sdram_addr), 32'h000091);
      wait_ok(0, 20);
      chk("cpu_dout_hi", 32'(cpu_dout), 32'hA5);
      cpu_addr = 15'h0122;
      tick();
      chk("cpu_dout_lo", 32'(cpu_dout), 32'h5A);
      chk("cpu_no_rd", 32'(sdram_rd), 32'd0);

      // object plane pair
      do_reset();
      obj_cs = 1'b1; obj_addr = 13'h0010;
      force_q.push_back(16'h1111); force_q.push_back(16'h2222);
      tick();
      chk("obj_a0", 32'(sdram_addr), 32'h006010);
      tick(); tick();
      chk("obj_rd2", 32'(sdram_rd), 32'd1);
      chk("obj_a1", 32'(sdram_addr), 32'h008010);
      wait_ok(2, 20);
      chk("obj_d0", 32'(obj_data0), 32'h1111);
      chk("obj_d1", 32'(obj_data1), 32'h2222);

      // priority with all three missing together
      do_reset();
      cpu_cs = 1'b1; cpu_addr = 15'h0246; bg_cs = 1'b1; bg_addr = 12'h055;
      obj_cs = 1'b1; obj_addr = 13'h00AA;
      n = 0;
      while (grant_q.size() < 4 && n < 60) begin tick(); n++; end
      exp_g[0] = 22'h0060AA; exp_g[1] = 22'h0080AA; exp_g[2] = 22'h004055; exp_g[3] = 22'h000123;
      for (int i = 0; i < 4; i++)
         chk("prio_order", 32'((i < grant_q.size()) ? grant_q[i] : 22'h3FFFFF), 32'(exp_g[i]));

      // CPU starvation under continuous object/background misses
      do_reset();
      cpu_cs = 1'b1; cpu_addr = 15'h0300; bg_cs = 1'b1; obj_cs = 1'b1;
      seen = 1'b0; n = 0;
      while (!seen && n < 200) begin
         obj_addr = obj_addr + 13'd1; bg_addr = bg_addr + 12'd1;
         tick(); n++;
         foreach (grant_q[i]) if (grant_q[i] < 22'h004000) seen = 1'b1;
      end
      lost = 0;
      foreach (grant_q[i]) begin
         if (grant_q[i] < 22'h004000) break;
         if (grant_q[i] < 22'h008000) lost++;
      end
      chk("starve_cpu_seen", 32'(seen), 32'd1);
      chk("starve_lost", 32'(lost), 32'd3);

      // background address change while waiting for data
      do_reset();
      bg_cs = 1'b1; bg_addr = 12'h001;
      tick(); tick();
      bg_addr = 12'h002;
      tick();
      chk("bgchg_ok", 32'(bg_ok), 32'd0);
      tick();
      chk("bgchg_rd", 32'(sdram_rd), 32'd1);
      chk("bgchg_addr", 32'(sdram_addr), 32'h004002);
      wait_ok(1, 20);

      // reset in the middle of the second object beat
      do_reset();
      cpu_cs = 1'b1; cpu_addr = 15'h0011;
      wait_ok(0, 20);
      obj_cs = 1'b1; obj_addr = 13'h0005;
      tick(); tick(); tick();
      chk("rst_pre_addr", 32'(sdram_addr), 32'h008005);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_rd", 32'(sdram_rd), 32'd0);
      chk("rst_mid_oks", {29'd0, cpu_ok, bg_ok, obj_ok}, 32'd0);
      do_reset();
      stray_force = 1'b1;
      tick();
      stray_force = 1'b0;
      chk("stray_cpu", 32'(cpu_dout), 32'd0);
      chk("stray_bg", 32'(bg_data), 32'd0);
      chk("stray_obj0", 32'(obj_data0), 32'd0);
      chk("stray_obj1", 32'(obj_data1), 32'd0);

      // randomized traffic with random SDRAM timing and stray pulses
      do_reset();
      rnd_mode = 1'b1; stray_en = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 7) == 0) cpu_cs = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 5) == 0) cpu_addr = 15'h1230 + 15'($urandom_range(0, 7));
         if ($urandom_range(0, 7) == 0) bg_cs = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 5) == 0) bg_addr = 12'hFFE + 12'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) obj_cs = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 5) == 0) obj_addr = 13'h1FFC + 13'($urandom_range(0, 3));
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
